// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int PERF_CNT_W = 32;

    typedef logic [0:0] req_idx_t;

    typedef struct packed {
        logic     locked;
        req_idx_t idx;
    } lock_owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a burst lock that pins the grant to its owner.
// Latency: grant is combinational from req_valid in the same cycle.
// Backpressure: while locked, only the owner can be granted and the other requester waits.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_lock,
    output logic [NUM_REQ-1:0] grant,
    output req_idx_t           grant_idx
);

    req_idx_t    rr_last;
    lock_owner_t owner;

    // Pick the winner: lock owner first, then the sole valid requester, then the one not served last
    always_comb begin
        grant = '0;
        if (owner.locked) begin
            if (req_valid[owner.idx]) begin
                grant[owner.idx] = 1'b1;
            end
        end else begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant[~rr_last] = 1'b1;
                default: grant = '0;
            endcase
        end
        grant_idx = grant[1];
    end

    // Remember who was served and whether that beat asked to keep the port; bubbles keep the lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
            owner   <= '0;
        end else if (|grant) begin
            rr_last <= grant_idx;
            owner   <= '{locked: req_lock[grant_idx], idx: grant_idx};
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between two valid/ready requesters; optional counters under MEM_ARB_PERF_EN.
// Latency: command reaches the SRAM in the grant cycle; read data returns one cycle later.
// Backpressure: losing requester sees req_ready=0; read responses cannot be stalled.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 256,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*STRB_WIDTH-1:0] req_wmask,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [STRB_WIDTH-1:0]         mem_wmask,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [NUM_REQ*PERF_CNT_W-1:0] perf_grant_cnt,
    output logic [NUM_REQ*PERF_CNT_W-1:0] perf_stall_cnt
`endif
);

    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] fire;
    logic [NUM_REQ-1:0] rsp_pend;
    req_idx_t           sel;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .grant     (grant),
        .grant_idx (sel)
    );

    assign req_ready = grant;
    assign fire      = req_valid & req_ready;

    // Steer the granted command onto the SRAM; with no grant sel is 0 so requester 0 drives addr/data
    always_comb begin
        mem_en    = |fire;
        mem_we    = mem_en & req_we[sel];
        mem_addr  = sel[0] ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]  : req_addr[0 +: ADDR_WIDTH];
        mem_wmask = sel[0] ? req_wmask[STRB_WIDTH +: STRB_WIDTH] : req_wmask[0 +: STRB_WIDTH];
        mem_wdata = sel[0] ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];
    end

    // Tag the requester whose read is in flight so the SRAM data is flagged back to it next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_pend <= '0;
        end else begin
            rsp_pend <= fire & ~req_we;
        end
    end

    assign rsp_valid = rsp_pend;
    assign rsp_rdata = mem_rdata;

`ifdef MEM_ARB_PERF_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
        logic [PERF_CNT_W-1:0] grant_cnt;
        logic [PERF_CNT_W-1:0] stall_cnt;

        // Saturating per-requester counts of accepted beats and of cycles spent waiting
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                grant_cnt <= '0;
                stall_cnt <= '0;
            end else begin
                if (fire[i] && (grant_cnt != '1)) begin
                    grant_cnt <= grant_cnt + 1'b1;
                end
                if (req_valid[i] && !req_ready[i] && (stall_cnt != '1)) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end
        end

        assign perf_grant_cnt[i*PERF_CNT_W +: PERF_CNT_W] = grant_cnt;
        assign perf_stall_cnt[i*PERF_CNT_W +: PERF_CNT_W] = stall_cnt;
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, hand-written corner sequences, random traffic.
// Latency: inputs driven at negedge, outputs sampled 1 time unit later.
// Backpressure: the bench only offers commands; the arbiter decides who is served.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 256;
    localparam int SW = DW / 8;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [1:0]      req_lock;
    logic [2*AW-1:0] req_addr;
    logic [2*SW-1:0] req_wmask;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [SW-1:0]   mem_wmask;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [63:0]     perf_grant_cnt;
    logic [63:0]     perf_stall_cnt;
`endif

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wmask (req_wmask),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SRAM model (1-cycle read latency) ----------------
    logic [DW-1:0] sram [1 << AW];

    function automatic logic [DW-1:0] init_word(input int a);
        logic [31:0] w;
        w = 32'(a) ^ 32'hC0DE_0000;
        return {8{w}};
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < SW; b++) begin
                    if (mem_wmask[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    // ---------------- reference model ----------------
    int            rm_pri;       // requester that wins when both ask
    bit            rm_locked;
    int            rm_owner;
    logic [1:0]    rm_pend;
    logic [DW-1:0] rm_data;
    logic [DW-1:0] ref_mem [1 << AW];
    logic [31:0]   rm_pg [2];
    logic [31:0]   rm_ps [2];

    int n_checks;
    int n_pass;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        rm_pri    = 0;
        rm_locked = 1'b0;
        rm_owner  = 0;
        rm_pend   = 2'b00;
        rm_data   = '0;
        rm_pg[0] = 0; rm_pg[1] = 0;
        rm_ps[0] = 0; rm_ps[1] = 0;
    endtask

    // One bus cycle: drive at negedge, check against the model, advance the model
    task automatic step(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [SW-1:0] m0, input logic [SW-1:0] m1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        int g;
        int sel;
        logic [1:0]    exp_rdy;
        logic [AW-1:0] a;
        logic [SW-1:0] m;
        logic [DW-1:0] d;
        @(negedge clk);
        req_valid = v;   req_we = we;   req_lock = lk;
        req_addr  = {a1, a0};
        req_wmask = {m1, m0};
        req_wdata = {d1, d0};
        #1;
        g = -1;
        if (rm_locked) begin
            if (v[rm_owner]) g = rm_owner;
        end else if (v == 2'b11) g = rm_pri;
        else if (v == 2'b01) g = 0;
        else if (v == 2'b10) g = 1;
        exp_rdy = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
        sel = (g == 1) ? 1 : 0;
        a = sel ? a1 : a0;
        m = sel ? m1 : m0;
        d = sel ? d1 : d0;
        chk("req_ready", 256'(req_ready), 256'(exp_rdy));
        chk("mem_en",    256'(mem_en),    256'(g >= 0));
        chk("mem_we",    256'(mem_we),    256'((g >= 0) && we[sel]));
        chk("mem_addr",  256'(mem_addr),  256'(a));
        chk("mem_wmask", 256'(mem_wmask), 256'(m));
        chk("mem_wdata", mem_wdata, d);
        chk("rsp_valid", 256'(rsp_valid), 256'(rm_pend));
        if (rm_pend != 2'b00) chk("rsp_rdata", rsp_rdata, rm_data);
        for (int i = 0; i < 2; i++) begin
            if (g == i && rm_pg[i] != 32'hFFFF_FFFF) rm_pg[i]++;
            if (v[i] && g != i && rm_ps[i] != 32'hFFFF_FFFF) rm_ps[i]++;
        end
        rm_pend = 2'b00;
        if (g >= 0) begin
            rm_pri    = 1 - g;
            rm_locked = lk[g];
            rm_owner  = g;
            if (we[g]) begin
                for (int b = 0; b < SW; b++) if (m[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
            end else begin
                rm_pend[g] = 1'b1;
                rm_data    = ref_mem[a];
            end
        end
    endtask

`ifdef MEM_ARB_PERF_EN
    task automatic chk_perf(input string tag);
        chk({tag, "_grant0"}, 256'(perf_grant_cnt[31:0]),  256'(rm_pg[0]));
        chk({tag, "_grant1"}, 256'(perf_grant_cnt[63:32]), 256'(rm_pg[1]));
        chk({tag, "_stall0"}, 256'(perf_stall_cnt[31:0]),  256'(rm_ps[0]));
        chk({tag, "_stall1"}, 256'(perf_stall_cnt[63:32]), 256'(rm_ps[1]));
    endtask
`endif

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]    v;
        logic [1:0]    we;
        logic [1:0]    lk;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [1:0]    exp_rdy;
        logic [1:0]    exp_rsp;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t tbl [13];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin : main
        int cnt0;
        int cnt1;
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i]    = init_word(i);
            ref_mem[i] = init_word(i);
        end
        mem_rdata = '0;
        rst_n     = 1'b0;
        req_valid = '0; req_we = '0; req_lock = '0;
        req_addr  = '0; req_wmask = '0; req_wdata = '0;
        model_reset();

        // Contention / lock burst with bubble / write-then-read
        tbl[0]  = '{2'b11, 2'b00, 2'b00, 10'h10, 10'h20, 2'b01, 2'b00, 10'h10};
        tbl[1]  = '{2'b11, 2'b00, 2'b00, 10'h10, 10'h20, 2'b10, 2'b01, 10'h20};
        tbl[2]  = '{2'b00, 2'b00, 2'b00, 10'h10, 10'h20, 2'b00, 2'b10, 10'h10};
        tbl[3]  = '{2'b11, 2'b00, 2'b10, 10'h30, 10'h40, 2'b01, 2'b00, 10'h30};
        tbl[4]  = '{2'b11, 2'b00, 2'b10, 10'h30, 10'h41, 2'b10, 2'b01, 10'h41};
        tbl[5]  = '{2'b11, 2'b00, 2'b10, 10'h30, 10'h42, 2'b10, 2'b10, 10'h42};
        tbl[6]  = '{2'b01, 2'b00, 2'b10, 10'h30, 10'h42, 2'b00, 2'b10, 10'h30};
        tbl[7]  = '{2'b11, 2'b00, 2'b10, 10'h30, 10'h43, 2'b10, 2'b00, 10'h43};
        tbl[8]  = '{2'b11, 2'b00, 2'b00, 10'h30, 10'h44, 2'b10, 2'b10, 10'h44};
        tbl[9]  = '{2'b01, 2'b00, 2'b00, 10'h31, 10'h00, 2'b01, 2'b10, 10'h31};
        tbl[10] = '{2'b01, 2'b01, 2'b00, 10'h05, 10'h00, 2'b01, 2'b01, 10'h05};
        tbl[11] = '{2'b01, 2'b00, 2'b00, 10'h05, 10'h00, 2'b01, 2'b00, 10'h05};
        tbl[12] = '{2'b00, 2'b00, 2'b00, 10'h00, 10'h00, 2'b00, 2'b01, 10'h00};

        // Reset state
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_ready",     256'(req_ready), 256'(2'b00));
        chk("rst_rsp_valid", 256'(rsp_valid), 256'(2'b00));
        chk("rst_mem_en",    256'(mem_en),    256'(1'b0));
        chk("rst_mem_we",    256'(mem_we),    256'(1'b0));
        req_valid = 2'b11;
        #1;
        chk("rst_priority", 256'(req_ready), 256'(2'b01));
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].v, tbl[i].we, tbl[i].lk, tbl[i].a0, tbl[i].a1,
                 32'h0000_000F, 32'hFFFF_0000, {32{8'hA5}}, {32{8'h5A}});
            chk($sformatf("tbl%0d_ready", i), 256'(req_ready), 256'(tbl[i].exp_rdy));
            chk($sformatf("tbl%0d_rsp", i),   256'(rsp_valid), 256'(tbl[i].exp_rsp));
            chk($sformatf("tbl%0d_addr", i),  256'(mem_addr),  256'(tbl[i].exp_addr));
        end

        // Asynchronous reset in the middle of a locked read burst
        step(2'b10, 2'b00, 2'b10, 10'h0, 10'h7, '0, '0, '0, '0);
        step(2'b11, 2'b00, 2'b10, 10'h0, 10'h8, '0, '0, '0, '0);
        chk("burst_owner_kept", 256'(req_ready), 256'(2'b10));
        @(negedge clk);
        #1;
        chk("pre_rst_rsp", 256'(rsp_valid), 256'(2'b10));
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_rsp",   256'(rsp_valid), 256'(2'b00));
        chk("async_rst_grant", 256'(req_ready), 256'(2'b01));
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b00;
        model_reset();

        // Continuous contention without lock: strict alternation starting at requester 0
        cnt0 = 0;
        cnt1 = 0;
        for (int k = 0; k < 10; k++) begin
            step(2'b11, 2'b00, 2'b00, AW'(k), AW'(k + 100), '0, '0, '0, '0);
            chk($sformatf("alt%0d", k), 256'(req_ready), 256'((k % 2) ? 2'b10 : 2'b01));
            if (req_ready == 2'b01) cnt0++;
            if (req_ready == 2'b10) cnt1++;
        end
        chk("alt_cnt0", 256'(cnt0), 256'(5));
        chk("alt_cnt1", 256'(cnt1), 256'(5));
`ifdef MEM_ARB_PERF_EN
        chk_perf("perf_alt");
        chk("perf_alt_g0_is5", 256'(perf_grant_cnt[31:0]),  256'(5));
        chk("perf_alt_g1_is5", 256'(perf_grant_cnt[63:32]), 256'(5));
`endif

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [DW-1:0] d0;
            logic [DW-1:0] d1;
            for (int w = 0; w < 8; w++) begin
                d0[w*32 +: 32] = $urandom;
                d1[w*32 +: 32] = $urandom;
            end
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)),
                 AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                 SW'($urandom), SW'($urandom), d0, d1);
        end
        step(2'b00, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
`ifdef MEM_ARB_PERF_EN
        chk_perf("perf_rand");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
